// File: rtl/mem_responder.sv
// Simulated host-memory target for the mem_req/mem_wr/mem_rd burst protocol, with a host backdoor port.
// Optional protocol checking on the sticky err output is compiled in with `define MEM_RESP_CHECK_EN.
module mem_responder #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int RD_LATENCY     = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]   mem_req_len,
  input  logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  input  logic                      mem_wr_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  output logic                      mem_rd_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  input  logic                      mem_rd_ready,
  output logic                      busy,
  output logic                      err,
  input  logic                      host_wr_en,
  input  logic [MEM_DEPTH_BITS-1:0] host_addr,
  input  logic [MEM_DATA_BITS-1:0]  host_wr_data,
  output logic [MEM_DATA_BITS-1:0]  host_rd_data
);

  localparam int DEPTH = 1 << MEM_DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA} state_t;

  state_t                    state_q, state_d;
  logic [MEM_DEPTH_BITS-1:0] index_q, index_d;
  logic [MEM_LEN_BITS-1:0]   beats_left_q, beats_left_d;
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [MEM_DATA_BITS-1:0]  rd_bits_q, rd_bits_d;
  logic                      wr_en;
  logic [MEM_DEPTH_BITS-1:0] req_idx;
  logic [MEM_DEPTH_BITS-1:0] index_inc;

  logic [MEM_DATA_BITS-1:0]  mem_q [DEPTH];

  assign req_idx   = mem_req_addr[MEM_DEPTH_BITS-1:0];
  assign index_inc = index_q + MEM_DEPTH_BITS'(1);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    beats_left_d = beats_left_q;
    wait_cnt_d   = wait_cnt_q;
    rd_valid_d   = rd_valid_q;
    rd_bits_d    = rd_bits_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          index_d      = req_idx;
          beats_left_d = mem_req_len;
          if (mem_req_opcode) begin
            state_d = WR_DATA;
          end else if (RD_LATENCY == 1) begin
            state_d    = RD_DATA;
            rd_valid_d = 1'b1;
            rd_bits_d  = mem_q[req_idx];
          end else begin
            state_d    = RD_WAIT;
            wait_cnt_d = 4'(RD_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        // The beat register is loaded on the edge the counter expires, so valid appears exactly RD_LATENCY after the request.
        if (wait_cnt_q <= 4'd1) begin
          state_d    = RD_DATA;
          wait_cnt_d = 4'd0;
          rd_valid_d = 1'b1;
          rd_bits_d  = mem_q[index_q];
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RD_DATA: begin
        if (mem_rd_ready) begin
          index_d = index_inc;
          if (beats_left_q == '0) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
          end else begin
            beats_left_d = beats_left_q - MEM_LEN_BITS'(1);
            rd_bits_d    = mem_q[index_inc];
          end
        end
      end
      WR_DATA: begin
        if (mem_wr_valid) begin
          wr_en   = 1'b1;
          index_d = index_inc;
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - MEM_LEN_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      beats_left_q <= '0;
      wait_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_bits_q    <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      beats_left_q <= beats_left_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_bits_q    <= rd_bits_d;
    end
  end

  // Contents survive reset; the protocol write is issued last so it wins a same-word collision.
  always_ff @(posedge clock) begin
    if (host_wr_en) begin
      mem_q[host_addr] <= host_wr_data;
    end
    if (wr_en && !reset) begin
      mem_q[index_q] <= mem_wr_bits;
    end
  end

  assign host_rd_data = mem_q[host_addr];
  assign mem_rd_valid = rd_valid_q;
  assign mem_rd_bits  = rd_bits_q;
  assign busy         = (state_q != IDLE);

`ifdef MEM_RESP_CHECK_EN
  logic err_q, err_d;
  logic addr_hi_set;

  assign addr_hi_set = |mem_req_addr[MEM_ADDR_BITS-1:MEM_DEPTH_BITS];

  always_comb begin
    err_d = err_q;
    if (mem_req_valid && (state_q != IDLE)) err_d = 1'b1;
    if (mem_wr_valid && (state_q != WR_DATA)) err_d = 1'b1;
    if (mem_req_valid && addr_hi_set) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:MEM_DEPTH_BITS];
  assign err            = 1'b0;
`endif

endmodule
